// File: rtl/uart_cmd_sequencer_pkg.sv
// Shared definitions for the UART command sequencer: opcodes, response bytes
// and frame FSM state encodings.
package uart_cmd_sequencer_pkg;

    localparam logic [7:0] OP_SET   = 8'h53;
    localparam logic [7:0] OP_TRIG  = 8'h5C;
    localparam logic [7:0] RSP_ACK  = 8'hA5;
    localparam logic [7:0] RSP_NAK  = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_ARG_CH  = 3'd2,
        ST_ARG_VAL = 3'd3,
        ST_RESP    = 3'd4
    } state_e;

    // True for the header bytes that open a frame
    function automatic logic is_opcode(input logic [7:0] b);
        return (b == OP_SET) || (b == OP_TRIG);
    endfunction

endpackage

// File: rtl/uart_cmd_sequencer_trig_pulse_gen.sv
// Fixed-width trigger pulse generator. A start while a pulse is running is
// ignored; the parent uses busy to decide ACK vs NAK.
module trig_pulse_gen #(
    parameter int unsigned TRIG_CYC = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic pulse
);

    localparam int unsigned CW = $clog2(TRIG_CYC + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(TRIG_CYC);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          pulse_q;
    logic          pulse_d;

    // Load on start from idle, count down to zero and stop there
    always_comb begin
        cnt_d   = cnt_q;
        pulse_d = pulse_q;
        if (cnt_q != CNT_ZERO) begin
            cnt_d = cnt_q - CNT_ONE;
        end else if (start) begin
            cnt_d = CNT_LOAD;
        end else begin
            cnt_d = CNT_ZERO;
        end
        pulse_d = (cnt_d != CNT_ZERO);
    end

    // Counter and registered pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= CNT_ZERO;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign busy  = pulse_q;
    assign pulse = pulse_q;

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Parses SET/TRIG frames from the UART RX byte stream, updates the channel
// vector registers, fires trigger pulses and returns ACK/NAK to the TX core.
module uart_cmd_sequencer
    import uart_cmd_sequencer_pkg::*;
#(
    parameter logic [7:0]  DEV_ADDR    = 8'h00,
    parameter int unsigned TIMEOUT_CYC = 25000,
    parameter int unsigned TRIG_CYC    = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] vctr_out,
    output logic [3:0]  trig_out,
    output logic        busy,
    output logic        ovr
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    state_e        state_q, state_d;
    logic [7:0]    opcode_q, opcode_d;
    logic [7:0]    ch_q, ch_d;
    logic [31:0]   vctr_q, vctr_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic          ovr_q, ovr_d;
    logic          busy_q, busy_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          trig_start_s;
    logic          pg_busy_s;
    logic          pg_pulse_s;
    logic          tmo_hit_s;

    assign tmo_hit_s = (tmo_q == TMO_MAX);

    // Frame FSM: next state, timeout counter, register updates and response
    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        ch_d         = ch_q;
        vctr_d       = vctr_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        ovr_d        = ovr_q;
        tmo_d        = tmo_q;
        trig_start_s = 1'b0;
        busy_d       = busy_q;

        case (state_q)
            ST_IDLE: begin
                tmo_d = TMO_ZERO;
                if (rx_valid && is_opcode(rx_data)) begin
                    opcode_d = rx_data;
                    state_d  = ST_ADDR;
                end else begin
                    state_d  = ST_IDLE;
                end
            end

            ST_ADDR: begin
                if (rx_valid) begin
                    tmo_d = TMO_ZERO;
                    if (rx_data != DEV_ADDR) begin
                        state_d = ST_IDLE;
                    end else if (opcode_q == OP_TRIG) begin
                        state_d    = ST_RESP;
                        tx_valid_d = 1'b1;
                        if (pg_busy_s) begin
                            tx_data_d = RSP_NAK;
                        end else begin
                            tx_data_d    = RSP_ACK;
                            trig_start_s = 1'b1;
                        end
                    end else begin
                        state_d = ST_ARG_CH;
                    end
                end else if (tmo_hit_s) begin
                    tmo_d   = TMO_ZERO;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d   = tmo_q + TMO_ONE;
                end
            end

            ST_ARG_CH: begin
                if (rx_valid) begin
                    tmo_d   = TMO_ZERO;
                    ch_d    = rx_data;
                    state_d = ST_ARG_VAL;
                end else if (tmo_hit_s) begin
                    tmo_d   = TMO_ZERO;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d   = tmo_q + TMO_ONE;
                end
            end

            ST_ARG_VAL: begin
                if (rx_valid) begin
                    tmo_d      = TMO_ZERO;
                    state_d    = ST_RESP;
                    tx_valid_d = 1'b1;
                    if (ch_q <= 8'd3) begin
                        vctr_d[{ch_q[1:0], 3'b000} +: 8] = rx_data;
                        tx_data_d = RSP_ACK;
                    end else begin
                        tx_data_d = RSP_NAK;
                    end
                end else if (tmo_hit_s) begin
                    tmo_d   = TMO_ZERO;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d   = tmo_q + TMO_ONE;
                end
            end

            ST_RESP: begin
                tmo_d = TMO_ZERO;
                // Bytes arriving before the response is taken are lost
                if (rx_valid) begin
                    ovr_d = 1'b1;
                end else begin
                    ovr_d = ovr_q;
                end
                if (tx_valid_q && tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    state_d    = ST_RESP;
                end
            end

            default: begin
                tmo_d      = TMO_ZERO;
                tx_valid_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            opcode_q   <= 8'h00;
            ch_q       <= 8'h00;
            vctr_q     <= 32'h0000_0000;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            ovr_q      <= 1'b0;
            busy_q     <= 1'b0;
            tmo_q      <= TMO_ZERO;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            ch_q       <= ch_d;
            vctr_q     <= vctr_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            ovr_q      <= ovr_d;
            busy_q     <= busy_d;
            tmo_q      <= tmo_d;
        end
    end

    trig_pulse_gen #(
        .TRIG_CYC (TRIG_CYC)
    ) u_trig (
        .clk   (clk),
        .rst   (rst),
        .start (trig_start_s),
        .busy  (pg_busy_s),
        .pulse (pg_pulse_s)
    );

    assign vctr_out = vctr_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign ovr      = ovr_q;
    assign trig_out = {4{pg_pulse_s}};

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Directed bench for uart_cmd_sequencer: frames are driven on the falling edge
// and outputs are compared on the falling edge against hand-computed values.
module tb_uart_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic [31:0] vctr_out;
    logic [3:0]  trig_out;
    logic        busy;
    logic        ovr;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_cmd_sequencer #(
        .DEV_ADDR    (8'h00),
        .TIMEOUT_CYC (25000),
        .TRIG_CYC    (12)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .vctr_out (vctr_out),
        .trig_out (trig_out),
        .busy     (busy),
        .ovr      (ovr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // One-cycle rx strobe; returns on the falling edge after the capturing edge
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic ack(input string tag, input logic [7:0] exp);
        chk({tag, "_txv"}, {31'd0, tx_valid}, 32'd1);
        chk({tag, "_txd"}, {24'd0, tx_data}, {24'd0, exp});
        @(negedge clk);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        chk({tag, "_txv_drop"}, {31'd0, tx_valid}, 32'd0);
        chk({tag, "_busy_drop"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic count_trig(output int n);
        n = 0;
        while (trig_out == 4'hF && n < 64) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;

        // Reset state
        idle(3);
        chk("rst_vctr", vctr_out, 32'h0);
        chk("rst_trig", {28'd0, trig_out}, 32'h0);
        chk("rst_txv", {31'd0, tx_valid}, 32'd0);
        chk("rst_txd", {24'd0, tx_data}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ovr", {31'd0, ovr}, 32'd0);
        rst = 1'b0;

        // SET ch1=03
        send(8'h53); send(8'h00); send(8'h01); send(8'h03);
        chk("set1_vctr", vctr_out, 32'h0000_0300);
        chk("set1_busy", {31'd0, busy}, 32'd1);
        ack("set1", 8'hA5);
        idle(3);
        chk("set1_once", {31'd0, tx_valid}, 32'd0);

        // SET ch2=15, then TRIG
        send(8'h53); send(8'h00); send(8'h02); send(8'h15);
        chk("set2_vctr", vctr_out, 32'h0015_0300);
        ack("set2", 8'hA5);
        send(8'h5C); send(8'h00);
        chk("trig_on", {28'd0, trig_out}, 32'hF);
        count_trig(n);
        chk("trig_width", n, 32'd12);
        chk("trig_off", {28'd0, trig_out}, 32'h0);
        ack("trig", 8'hA5);

        // Out-of-range channel
        send(8'h53); send(8'h00); send(8'h07); send(8'h44);
        chk("badch_vctr", vctr_out, 32'h0015_0300);
        ack("badch", 8'h15);

        // Headerless bytes are ignored
        send(8'h00); send(8'h00); send(8'h02); send(8'h15);
        chk("nohdr_busy", {31'd0, busy}, 32'd0);
        chk("nohdr_txv", {31'd0, tx_valid}, 32'd0);
        chk("nohdr_vctr", vctr_out, 32'h0015_0300);

        // Wrong address
        send(8'h53); send(8'h01);
        chk("badaddr_busy", {31'd0, busy}, 32'd0);
        send(8'h02); send(8'h15);
        chk("badaddr_txv", {31'd0, tx_valid}, 32'd0);
        chk("badaddr_vctr", vctr_out, 32'h0015_0300);

        // Gap just under the timeout keeps the frame alive
        send(8'h53); send(8'h00);
        idle(24990);
        chk("tmo_alive", {31'd0, busy}, 32'd1);
        send(8'h02); send(8'h77);
        chk("tmo_alive_vctr", vctr_out, 32'h0077_0300);
        ack("tmo_alive", 8'hA5);

        // Gap past the timeout aborts the frame
        send(8'h53); send(8'h00);
        idle(25010);
        chk("tmo_abort_busy", {31'd0, busy}, 32'd0);
        send(8'h02); send(8'h66);
        chk("tmo_abort_vctr", vctr_out, 32'h0077_0300);
        chk("tmo_abort_txv", {31'd0, tx_valid}, 32'd0);
        chk("tmo_abort_busy2", {31'd0, busy}, 32'd0);

        // Byte during RESP sets ovr and is dropped
        send(8'h53); send(8'h00); send(8'h00); send(8'hAA);
        chk("ovr_vctr", vctr_out, 32'h0077_03AA);
        chk("ovr_pre", {31'd0, ovr}, 32'd0);
        send(8'h5C);
        chk("ovr_set", {31'd0, ovr}, 32'd1);
        chk("ovr_busy", {31'd0, busy}, 32'd1);
        ack("ovr", 8'hA5);
        chk("ovr_sticky", {31'd0, ovr}, 32'd1);
        chk("ovr_notrig", {28'd0, trig_out}, 32'h0);

        // TRIG twice within one pulse
        send(8'h5C); send(8'h00);
        chk("dbl_on", {28'd0, trig_out}, 32'hF);
        ack("dbl1", 8'hA5);
        send(8'h5C); send(8'h00);
        chk("dbl_nak", {24'd0, tx_data}, 32'h15);
        count_trig(n);
        chk("dbl_rest", n, 32'd6);
        ack("dbl2", 8'h15);

        // Reset mid-pulse and mid-frame
        send(8'h5C); send(8'h00);
        ack("rp_trig", 8'hA5);
        send(8'h53); send(8'h00); send(8'h01);
        chk("rp_trig_on", {28'd0, trig_out}, 32'hF);
        chk("rp_busy_on", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rp_vctr", vctr_out, 32'h0);
        chk("rp_trig", {28'd0, trig_out}, 32'h0);
        chk("rp_busy", {31'd0, busy}, 32'd0);
        chk("rp_ovr", {31'd0, ovr}, 32'd0);
        chk("rp_txv", {31'd0, tx_valid}, 32'd0);
        rst = 1'b0;
        send(8'h53); send(8'h00); send(8'h03); send(8'hC3);
        chk("post_vctr", vctr_out, 32'hC300_0000);
        ack("post_set", 8'hA5);
        send(8'h5C); send(8'h00);
        chk("post_trig", {28'd0, trig_out}, 32'hF);
        ack("post_trig", 8'hA5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
